// File: rtl/usb_ep_router.sv
// Bulk endpoint router: per-endpoint IN/OUT FIFOs with toggles, NAK and commit/rollback.
// Optional feature macro USB_EP_STALL_EN adds halt_in/halt_out and the STALL handshake.
module usb_ep_router #(
    parameter int NUM_EP  = 2,
    parameter int DEPTH   = 128,
    parameter int MAX_PKT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  usb_rst,
    input  logic                  transaction_active,
    input  logic [3:0]            endpoint,
    input  logic                  direction_in,
    input  logic                  setup,
    input  logic                  data_strobe,
    input  logic                  success,
    input  logic [7:0]            data_out,
`ifdef USB_EP_STALL_EN
    input  logic [NUM_EP-1:0]     halt_in,
    input  logic [NUM_EP-1:0]     halt_out,
`endif
    output logic [7:0]            data_in,
    output logic                  data_in_valid,
    output logic [1:0]            handshake,
    output logic                  data_toggle,
    input  logic [NUM_EP-1:0]     in_wr_en,
    input  logic [8*NUM_EP-1:0]   in_wr_data,
    output logic [NUM_EP-1:0]     in_full,
    input  logic [NUM_EP-1:0]     out_rd_en,
    output logic [8*NUM_EP-1:0]   out_rd_data,
    output logic [NUM_EP-1:0]     out_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;
    localparam int CW = $clog2(MAX_PKT + 1);
    localparam logic [PW-1:0] NAK_USED = PW'(DEPTH - MAX_PKT);
    localparam logic [CW-1:0] PKT_MAX  = CW'(MAX_PKT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PASS,
        S_IN,
        S_OUT
    } state_t;

    state_t state_q, state_d;

    logic          rst_all;
    logic          ta_q;
    logic          rise;
    logic          fall;
    logic          routed;
    logic [EW-1:0] ep_idx;
    logic [PW-1:0] used_d;
    logic          nak_d;
    logic          halt_d;
    logic          commit;
    logic          in_avail;
    logic          in_step;
    logic          out_wr_en;

    logic [EW-1:0] sel_q;
    logic [PW-1:0] shadow_q;
    logic [CW-1:0] cnt_q;
    logic          nak_q;
    logic          halt_q;
    logic          ovf_q;

    logic [PW-1:0] in_rd  [NUM_EP];
    logic [PW-1:0] in_wr  [NUM_EP];
    logic [PW-1:0] out_rd [NUM_EP];
    logic [PW-1:0] out_wr [NUM_EP];
    logic [NUM_EP-1:0] tog_in;
    logic [NUM_EP-1:0] tog_out;

    logic [7:0] in_mem  [NUM_EP][DEPTH];
    logic [7:0] out_mem [NUM_EP][DEPTH];

    assign rst_all = !rst || usb_rst;
    assign rise    = transaction_active && !ta_q;
    assign fall    = !transaction_active && ta_q;

    // Decode the token at the start of a transaction and decide NAK/STALL up front.
    always_comb begin
        ep_idx = EW'(endpoint - 4'd1);
        routed = !setup && (endpoint != 4'd0) && (int'(endpoint) <= NUM_EP);
        used_d = out_wr[ep_idx] - out_rd[ep_idx];
        if (direction_in) begin
            nak_d = (in_wr[ep_idx] == in_rd[ep_idx]);
        end else begin
            nak_d = (used_d > NAK_USED);
        end
`ifdef USB_EP_STALL_EN
        halt_d = direction_in ? halt_in[ep_idx] : halt_out[ep_idx];
`else
        halt_d = 1'b0;
`endif
    end

    assign in_avail  = (shadow_q != in_wr[sel_q]) && (cnt_q < PKT_MAX);
    assign in_step   = (state_q == S_IN) && data_strobe && data_in_valid;
    assign out_wr_en = (state_q == S_OUT) && data_strobe && !nak_q
                       && !halt_q && (cnt_q < PKT_MAX);
    assign commit    = fall && ((state_q == S_IN) || (state_q == S_OUT))
                       && !nak_q && !halt_q && !ovf_q && success;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst_all) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and core-facing outputs.
    always_comb begin
        state_d       = state_q;
        handshake     = 2'b01;
        data_in_valid = 1'b0;
        data_in       = 8'h00;
        data_toggle   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (rise) begin
                    if (!routed) begin
                        state_d = S_PASS;
                    end else if (direction_in) begin
                        state_d = S_IN;
                    end else begin
                        state_d = S_OUT;
                    end
                end
            end
            S_PASS: begin
                if (fall) state_d = S_IDLE;
            end
            S_IN: begin
                handshake   = halt_q ? 2'b11 : (nak_q ? 2'b10 : 2'b00);
                data_toggle = tog_in[sel_q];
                if (!nak_q && !halt_q) begin
                    data_in       = in_mem[sel_q][shadow_q[AW-1:0]];
                    data_in_valid = in_avail;
                end
                if (fall) state_d = S_IDLE;
            end
            S_OUT: begin
                handshake   = halt_q ? 2'b11 : (nak_q ? 2'b10 : 2'b00);
                data_toggle = tog_out[sel_q];
                if (fall) state_d = S_IDLE;
            end
        endcase
    end

    // Open-packet context: selection, shadow pointer, byte count, overflow.
    always_ff @(posedge clk) begin
        if (rst_all) begin
            ta_q     <= transaction_active;
            sel_q    <= '0;
            shadow_q <= '0;
            cnt_q    <= '0;
            nak_q    <= 1'b0;
            halt_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            ta_q <= transaction_active;
            if ((state_q == S_IDLE) && rise) begin
                sel_q    <= ep_idx;
                nak_q    <= nak_d;
                halt_q   <= halt_d;
                ovf_q    <= 1'b0;
                cnt_q    <= '0;
                shadow_q <= direction_in ? in_rd[ep_idx] : out_wr[ep_idx];
            end else if (in_step || out_wr_en) begin
                shadow_q <= shadow_q + PW'(1);
                cnt_q    <= cnt_q + CW'(1);
            end else if ((state_q == S_OUT) && data_strobe && !nak_q && !halt_q) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Byte storage; the OUT side is written speculatively beyond wr_ptr.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_EP; i++) begin
            if (!rst_all && in_wr_en[i] && !in_full[i]) begin
                in_mem[i][in_wr[i][AW-1:0]] <= in_wr_data[8*i +: 8];
            end
        end
        if (!rst_all && out_wr_en) begin
            out_mem[sel_q][shadow_q[AW-1:0]] <= data_out;
        end
    end

    // Committed pointers and toggles: user push/pop plus packet commit.
    always_ff @(posedge clk) begin
        if (rst_all) begin
            for (int i = 0; i < NUM_EP; i++) begin
                in_rd[i]  <= '0;
                in_wr[i]  <= '0;
                out_rd[i] <= '0;
                out_wr[i] <= '0;
            end
            tog_in  <= '0;
            tog_out <= '0;
        end else begin
            for (int i = 0; i < NUM_EP; i++) begin
                if (in_wr_en[i] && !in_full[i]) begin
                    in_wr[i] <= in_wr[i] + PW'(1);
                end
                if (out_rd_en[i] && !out_empty[i]) begin
                    out_rd[i] <= out_rd[i] + PW'(1);
                end
                if (commit && (sel_q == EW'(i))) begin
                    if (state_q == S_IN) begin
                        in_rd[i]  <= shadow_q;
                        tog_in[i] <= !tog_in[i];
                    end else begin
                        out_wr[i]  <= shadow_q;
                        tog_out[i] <= !tog_out[i];
                    end
                end
`ifdef USB_EP_STALL_EN
                if (halt_in[i])  tog_in[i]  <= 1'b0;
                if (halt_out[i]) tog_out[i] <= 1'b0;
`endif
            end
        end
    end

    // User-facing status and first-word-fall-through OUT head.
    always_comb begin
        in_full     = '0;
        out_empty   = '0;
        out_rd_data = '0;
        for (int i = 0; i < NUM_EP; i++) begin
            in_full[i]  = (in_wr[i][AW] != in_rd[i][AW])
                          && (in_wr[i][AW-1:0] == in_rd[i][AW-1:0]);
            out_empty[i] = (out_wr[i] == out_rd[i]);
            out_rd_data[8*i +: 8] = out_mem[i][out_rd[i][AW-1:0]];
        end
    end

endmodule

// File: tb/tb_usb_ep_router.sv
// Testbench for usb_ep_router: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized transactions.
module tb_usb_ep_router;

    localparam int NUM_EP  = 2;
    localparam int DEPTH   = 128;
    localparam int MAX_PKT = 64;

    logic                clk;
    logic                rst;
    logic                usb_rst;
    logic                transaction_active;
    logic [3:0]          endpoint;
    logic                direction_in;
    logic                setup;
    logic                data_strobe;
    logic                success;
    logic [7:0]          data_out;
    logic [7:0]          data_in;
    logic                data_in_valid;
    logic [1:0]          handshake;
    logic                data_toggle;
    logic [NUM_EP-1:0]   in_wr_en;
    logic [8*NUM_EP-1:0] in_wr_data;
    logic [NUM_EP-1:0]   in_full;
    logic [NUM_EP-1:0]   out_rd_en;
    logic [8*NUM_EP-1:0] out_rd_data;
    logic [NUM_EP-1:0]   out_empty;
    logic [NUM_EP-1:0]   halt_in;
    logic [NUM_EP-1:0]   halt_out;

    usb_ep_router #(
        .NUM_EP(NUM_EP),
        .DEPTH(DEPTH),
        .MAX_PKT(MAX_PKT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .usb_rst(usb_rst),
        .transaction_active(transaction_active),
        .endpoint(endpoint),
        .direction_in(direction_in),
        .setup(setup),
        .data_strobe(data_strobe),
        .success(success),
        .data_out(data_out),
`ifdef USB_EP_STALL_EN
        .halt_in(halt_in),
        .halt_out(halt_out),
`endif
        .data_in(data_in),
        .data_in_valid(data_in_valid),
        .handshake(handshake),
        .data_toggle(data_toggle),
        .in_wr_en(in_wr_en),
        .in_wr_data(in_wr_data),
        .in_full(in_full),
        .out_rd_en(out_rd_en),
        .out_rd_data(out_rd_data),
        .out_empty(out_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] q_in  [NUM_EP][$];
    logic [7:0] q_out [NUM_EP][$];
    logic [7:0] pkt [$];
    bit         tog_m [NUM_EP][2];
    int         m_mode;
    int         m_ep;
    int         m_sent;
    bit         m_dir;
    bit         m_ovf;
    bit         m_ta;
    logic [1:0] m_hs;

    bit cmp_en;
    bit rand_user;
    int pop_div;
    int errors;
    int checks;

    logic [1:0] cap_hs;
    logic       cap_tog;
    logic [7:0] cap_din;
    logic       cap_valid0;
    logic       cap_valid_end;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit m_valid();
        return (m_mode == 2) && (m_hs == 2'b00) && (m_sent < MAX_PKT)
               && (m_sent < q_in[m_ep].size());
    endfunction

    task automatic model_step();
        bit rise;
        bit fall;
        bit do_push [NUM_EP];
        bit do_pop  [NUM_EP];
        bit halted;
        if (!rst || usb_rst) begin
            for (int i = 0; i < NUM_EP; i++) begin
                q_in[i].delete();
                q_out[i].delete();
                tog_m[i][0] = 1'b0;
                tog_m[i][1] = 1'b0;
            end
            m_mode = 0;
            m_hs   = 2'b01;
            m_ta   = transaction_active;
            return;
        end
        for (int i = 0; i < NUM_EP; i++) begin
            do_push[i] = in_wr_en[i] && (q_in[i].size() < DEPTH);
            do_pop[i]  = out_rd_en[i] && (q_out[i].size() > 0);
        end
        rise = transaction_active && !m_ta;
        fall = !transaction_active && m_ta;
        if (m_mode >= 2 && data_strobe && m_hs == 2'b00) begin
            if (m_mode == 2) begin
                if (m_valid()) m_sent++;
            end else if (pkt.size() < MAX_PKT) begin
                pkt.push_back(data_out);
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (fall) begin
            if (m_mode >= 2 && m_hs == 2'b00 && success && !m_ovf) begin
                if (m_mode == 2) begin
                    for (int k = 0; k < m_sent; k++) void'(q_in[m_ep].pop_front());
                end else begin
                    foreach (pkt[k]) q_out[m_ep].push_back(pkt[k]);
                end
                tog_m[m_ep][m_dir] = !tog_m[m_ep][m_dir];
            end
            m_mode = 0;
            m_hs   = 2'b01;
        end else if (rise && m_mode == 0) begin
            if (setup || endpoint == 4'd0 || int'(endpoint) > NUM_EP) begin
                m_mode = 1;
                m_hs   = 2'b01;
            end else begin
                m_ep   = int'(endpoint) - 1;
                m_dir  = direction_in;
                m_sent = 0;
                m_ovf  = 1'b0;
                pkt.delete();
                m_mode = direction_in ? 2 : 3;
                halted = 1'b0;
`ifdef USB_EP_STALL_EN
                halted = direction_in ? halt_in[m_ep] : halt_out[m_ep];
`endif
                if (halted) m_hs = 2'b11;
                else if (direction_in) m_hs = (q_in[m_ep].size() == 0) ? 2'b10 : 2'b00;
                else m_hs = ((DEPTH - q_out[m_ep].size()) < MAX_PKT) ? 2'b10 : 2'b00;
            end
        end
`ifdef USB_EP_STALL_EN
        for (int i = 0; i < NUM_EP; i++) begin
            if (halt_in[i])  tog_m[i][1] = 1'b0;
            if (halt_out[i]) tog_m[i][0] = 1'b0;
        end
`endif
        for (int i = 0; i < NUM_EP; i++) begin
            if (do_push[i]) q_in[i].push_back(in_wr_data[8*i +: 8]);
            if (do_pop[i]) void'(q_out[i].pop_front());
        end
        m_ta = transaction_active;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (rand_user) begin
            for (int i = 0; i < NUM_EP; i++) begin
                in_wr_en[i] = ($urandom_range(0, 3) == 0);
                in_wr_data[8*i +: 8] = 8'($urandom);
                out_rd_en[i] = ($urandom_range(0, pop_div - 1) == 0);
            end
        end
    endtask

    task automatic txn(input int ep, input bit dir, input bit stp,
                       input int n, input bit succ);
        transaction_active = 1'b1;
        endpoint     = 4'(ep);
        direction_in = dir;
        setup        = stp;
        tick();
        cap_hs     = handshake;
        cap_tog    = data_toggle;
        cap_din    = data_in;
        cap_valid0 = data_in_valid;
        for (int i = 0; i < n; i++) begin
            data_strobe = 1'b1;
            data_out    = 8'($urandom);
            tick();
            data_strobe = 1'b0;
            tick();
        end
        cap_valid_end = data_in_valid;
        transaction_active = 1'b0;
        success = succ;
        tick();
        success = 1'b0;
        setup   = 1'b0;
        tick();
    endtask

    task automatic push_in(input int ch, input int n, input int base);
        for (int i = 0; i < n; i++) begin
            in_wr_en = '0;
            in_wr_en[ch] = 1'b1;
            in_wr_data = '0;
            in_wr_data[8*ch +: 8] = 8'(base + i);
            tick();
        end
        in_wr_en = '0;
    endtask

    task automatic pop_out(input int ch, input int n);
        for (int i = 0; i < n; i++) begin
            out_rd_en = '0;
            out_rd_en[ch] = 1'b1;
            tick();
        end
        out_rd_en = '0;
    endtask

    // Per-cycle comparison of every meaningful output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < NUM_EP; i++) begin
                chk($sformatf("in_full%0d", i), 32'(in_full[i]),
                    32'(q_in[i].size() == DEPTH));
                chk($sformatf("out_empty%0d", i), 32'(out_empty[i]),
                    32'(q_out[i].size() == 0));
                if (q_out[i].size() > 0) begin
                    chk($sformatf("out_rd_data%0d", i), 32'(out_rd_data[8*i +: 8]),
                        32'(q_out[i][0]));
                end
            end
            chk("handshake", 32'(handshake), 32'(m_hs));
            chk("data_in_valid", 32'(data_in_valid), 32'(m_valid()));
            if (m_valid()) chk("data_in", 32'(data_in), 32'(q_in[m_ep][m_sent]));
            chk("data_toggle", 32'(data_toggle),
                32'((m_mode >= 2) ? tog_m[m_ep][m_dir] : 1'b0));
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        errors = 0;
        checks = 0;
        cmp_en = 1'b0;
        rand_user = 1'b0;
        pop_div = 3;
        rst = 1'b0;
        usb_rst = 1'b0;
        transaction_active = 1'b0;
        endpoint = '0;
        direction_in = 1'b0;
        setup = 1'b0;
        data_strobe = 1'b0;
        success = 1'b0;
        data_out = '0;
        in_wr_en = '0;
        in_wr_data = '0;
        out_rd_en = '0;
        halt_in = '0;
        halt_out = '0;
        m_mode = 0;
        m_ep = 0;
        m_sent = 0;
        m_dir = 1'b0;
        m_ovf = 1'b0;
        m_ta = 1'b0;
        m_hs = 2'b01;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        cmp_en = 1'b1;

        chk("rst_hs", 32'(handshake), 32'h1);
        chk("rst_valid", 32'(data_in_valid), 32'h0);
        chk("rst_din", 32'(data_in), 32'h0);
        chk("rst_in_full", 32'(in_full), 32'h0);
        chk("rst_out_empty", 32'(out_empty), 32'h3);

        // Short IN packet on EP1
        push_in(0, 10, 1);
        txn(1, 1'b1, 1'b0, 10, 1'b1);
        chk("t1_hs", 32'(cap_hs), 32'h0);
        chk("t1_tog", 32'(cap_tog), 32'h0);
        chk("t1_din0", 32'(cap_din), 32'h01);
        chk("t1_valid0", 32'(cap_valid0), 32'h1);
        chk("t1_valid_end", 32'(cap_valid_end), 32'h0);
        txn(1, 1'b1, 1'b0, 0, 1'b0);
        chk("t1_nak", 32'(cap_hs), 32'h2);
        chk("t1_tog1", 32'(cap_tog), 32'h1);

        // OUT rollback then commit on EP1
        txn(1, 1'b0, 1'b0, 20, 1'b0);
        chk("t4_tog", 32'(cap_tog), 32'h0);
        chk("t4_empty_fail", 32'(out_empty[0]), 32'h1);
        txn(1, 1'b0, 1'b0, 20, 1'b1);
        chk("t4_tog_retry", 32'(cap_tog), 32'h0);
        chk("t4_empty_ok", 32'(out_empty[0]), 32'h0);
        pop_out(0, 20);
        chk("t4_drained", 32'(out_empty[0]), 32'h1);
        txn(1, 1'b0, 1'b0, 0, 1'b0);
        chk("t4_tog1", 32'(cap_tog), 32'h1);

        // 100 bytes on EP2 IN: max packet, resend, remainder
        push_in(1, 100, 0);
        txn(2, 1'b1, 1'b0, 64, 1'b0);
        chk("t2_hs", 32'(cap_hs), 32'h0);
        chk("t2_din", 32'(cap_din), 32'h0);
        chk("t2_valid_end", 32'(cap_valid_end), 32'h0);
        txn(2, 1'b1, 1'b0, 64, 1'b1);
        chk("t2_resend_din", 32'(cap_din), 32'h0);
        chk("t2_resend_tog", 32'(cap_tog), 32'h0);
        txn(2, 1'b1, 1'b0, 36, 1'b1);
        chk("t2_rem_din", 32'(cap_din), 32'd64);
        chk("t2_rem_tog", 32'(cap_tog), 32'h1);
        chk("t2_rem_valid_end", 32'(cap_valid_end), 32'h0);
        txn(2, 1'b1, 1'b0, 0, 1'b0);
        chk("t2_empty_nak", 32'(cap_hs), 32'h2);

        // OUT NAK when free space below max packet
        txn(1, 1'b0, 1'b0, 64, 1'b1);
        txn(1, 1'b0, 1'b0, 1, 1'b1);
        txn(1, 1'b0, 1'b0, 5, 1'b1);
        chk("t3_nak", 32'(cap_hs), 32'h2);
        pop_out(0, 1);
        txn(1, 1'b0, 1'b0, 5, 1'b1);
        chk("t3_ack", 32'(cap_hs), 32'h0);
        pop_out(0, 80);
        txn(1, 1'b0, 1'b0, MAX_PKT + 3, 1'b1);
        chk("t3_ovf_discard", 32'(out_empty[0]), 32'h1);

        // IN full boundary
        push_in(0, DEPTH + 2, 7);
        chk("full_set", 32'(in_full[0]), 32'h1);
        txn(1, 1'b1, 1'b0, 64, 1'b1);
        chk("full_clear", 32'(in_full[0]), 32'h0);

        // Unrouted tokens
        txn(0, 1'b1, 1'b0, 3, 1'b1);
        chk("ep0_hs", 32'(cap_hs), 32'h1);
        txn(1, 1'b1, 1'b1, 3, 1'b1);
        chk("setup_hs", 32'(cap_hs), 32'h1);
        txn(NUM_EP + 1, 1'b0, 1'b0, 3, 1'b1);
        chk("epmax_hs", 32'(cap_hs), 32'h1);

        // Bus reset in the middle of an IN packet
        push_in(1, 5, 9);
        transaction_active = 1'b1;
        endpoint = 4'd1;
        direction_in = 1'b1;
        tick();
        repeat (2) begin
            data_strobe = 1'b1;
            tick();
            data_strobe = 1'b0;
            tick();
        end
        usb_rst = 1'b1;
        tick();
        chk("ur_hs", 32'(handshake), 32'h1);
        chk("ur_valid", 32'(data_in_valid), 32'h0);
        chk("ur_din", 32'(data_in), 32'h0);
        chk("ur_in_full", 32'(in_full), 32'h0);
        chk("ur_out_empty", 32'(out_empty), 32'h3);
        transaction_active = 1'b0;
        tick();
        usb_rst = 1'b0;
        tick();
        txn(1, 1'b1, 1'b0, 0, 1'b0);
        chk("ur_in_empty", 32'(cap_hs), 32'h2);
        chk("ur_tog", 32'(cap_tog), 32'h0);

`ifdef USB_EP_STALL_EN
        push_in(0, 3, 1);
        halt_in = 2'b01;
        txn(1, 1'b1, 1'b0, 3, 1'b1);
        chk("stall_hs", 32'(cap_hs), 32'h3);
        chk("stall_valid", 32'(cap_valid0), 32'h0);
        halt_in = '0;
        txn(1, 1'b1, 1'b0, 0, 1'b0);
        chk("stall_kept", 32'(cap_valid0), 32'h1);
`endif

        // Randomized traffic with concurrent user push/pop
        rand_user = 1'b1;
        for (int t = 0; t < 60; t++) begin
            int  ep;
            bit  dir;
            bit  stp;
            int  n;
            bit  succ;
            pop_div = (t < 30) ? 20 : 3;
            ep   = $urandom_range(0, NUM_EP + 1);
            dir  = 1'($urandom_range(0, 1));
            stp  = ($urandom_range(0, 7) == 0);
            n    = dir ? $urandom_range(0, MAX_PKT) : $urandom_range(0, MAX_PKT + 3);
            succ = ($urandom_range(0, 3) != 0);
            txn(ep, dir, stp, n, succ);
        end
        rand_user = 1'b0;
        in_wr_en = '0;
        out_rd_en = '0;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
